// File: rtl/accu_window_ctrl.sv
// Sequencing controller for the windowed accumulator: clears it per window, gates its
// enable per accepted sample, and hands the finished sum out over a valid/ready port.
module accu_window_ctrl #(
  parameter int DATA_W = 37,
  parameter int WINDOW = 50,
  parameter int CNT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              cont,
  input  logic              abort,
  input  logic              s_valid,
  input  logic [DATA_W-1:0] s_data,
  output logic              s_ready,
  output logic              accu_clr,
  output logic              accu_en_n,
  output logic [DATA_W-1:0] accu_din,
  input  logic [DATA_W:0]   accu_dout,
  output logic              m_valid,
  output logic [DATA_W:0]   m_data,
  input  logic              m_ready,
  output logic              busy,
  output logic [CNT_W-1:0]  win_cnt
);

  typedef enum logic [2:0] {
    S_IDLE, S_CLEAR, S_ACCUM, S_CAPTURE, S_OUT
  } state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WINDOW - 1);

  state_t            r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_m_valid;
  logic [DATA_W:0]   r_m_data;
  logic              w_acc;

  // abort blocks acceptance in the same cycle so the accumulator never sees a stray sample
  assign s_ready   = (r_state == S_ACCUM) & ~abort;
  assign w_acc     = s_valid & s_ready;
  assign accu_en_n = ~w_acc;
  assign accu_din  = s_data;
  assign accu_clr  = ~rst & (abort | (r_state == S_CLEAR));
  assign busy      = (r_state != S_IDLE);
  assign win_cnt   = r_cnt;
  assign m_valid   = r_m_valid;
  assign m_data    = r_m_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_m_valid <= 1'b0;
      r_m_data  <= '0;
    end else if (abort) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_m_valid <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) r_state <= S_CLEAR;
        end
        S_CLEAR: begin
          r_cnt   <= '0;
          r_state <= S_ACCUM;
        end
        S_ACCUM: begin
          if (w_acc) begin
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == LAST) r_state <= S_CAPTURE;
          end
        end
        S_CAPTURE: begin
          // accumulator has one cycle of latency, so dout already holds the last sample here
          r_m_data  <= accu_dout;
          r_m_valid <= 1'b1;
          r_state   <= S_OUT;
        end
        S_OUT: begin
          if (m_ready) begin
            r_m_valid <= 1'b0;
            r_state   <= cont ? S_CLEAR : S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: doc/accu_window_ctrl.md
Name: accu_window_ctrl

Overview:
Sequencing controller for the windowed accumulator datapath. It accepts a valid/ready sample stream and clears the accumulator at each window start. It gates the accumulator's active-low enable per accepted sample, counts WINDOW samples, then captures the finished sum and presents it on a valid/ready result port. It supports single-shot and continuous window modes and sits between the upstream sample producer and the downstream FIFO.

Parameters:
DATA_W, 37, sample width, matching the accumulator input_width
WINDOW, 50, samples per accumulation window (2..2^CNT_W-1)
CNT_W, 6, width of the sample counter

Ports:
clk  in  1  clock
rst  in  1  reset, asynchronous, active-high
start  in  1  pulse: begin a window (ignored unless IDLE)
cont  in  1  1 = automatically start the next window after the result handshake
abort  in  1  synchronous abort from any state
s_valid  in  1  upstream sample valid
s_data  in  DATA_W  signed sample
s_ready  out  1  controller accepts a sample this cycle
accu_clr  out  1  to accumulator rst (sync, active-high)
accu_en_n  out  1  to accumulator en (active-low)
accu_din  out  DATA_W  to accumulator din
accu_dout  in  DATA_W+1  signed sum from accumulator
m_valid  out  1  result valid
m_data  out  DATA_W+1  signed window sum
m_ready  in  1  downstream accepts the result
busy  out  1  state != IDLE
win_cnt  out  CNT_W  samples accepted in the current window

Behaviour:
- Reset is asynchronous and active-high.
  - state=IDLE, win_cnt=0, m_valid=0, m_data=0.
  - Outputs during reset: s_ready=0, accu_en_n=1, accu_clr=0, busy=0.
- accu_din = s_data (combinational).
- accu_en_n = ~(s_valid & s_ready): the accumulator adds only accepted samples.
- IDLE: s_ready=0. If start=1 and abort=0, go to CLEAR.
- CLEAR (1 cycle): accu_clr=1, win_cnt<=0, then go to ACCUM.
- ACCUM:
  - s_ready=1; each cycle with s_valid=1 is an accepted sample and increments win_cnt.
  - Gaps in s_valid stall without penalty.
  - When a sample is accepted with win_cnt==WINDOW-1, go to CAPTURE (win_cnt reads WINDOW).
- CAPTURE (1 cycle):
  - s_ready=0. accu_dout now includes the last sample (one-cycle accumulator latency).
  - m_data<=accu_dout, m_valid<=1, then go to OUT.
- OUT:
  - s_ready=0. m_valid and m_data stay stable until m_ready=1.
  - On handshake: m_valid<=0. Go to CLEAR if cont=1 (sampled at the handshake cycle), else go to IDLE.
- Latency: last accepted sample at edge N gives m_valid=1 from cycle N+2.
- Continuous throughput with no stalls: one result per WINDOW+3 cycles.
- abort=1 from any non-IDLE state:
  - Next state is IDLE, m_valid<=0, win_cnt<=0.
  - accu_clr=1 in the abort cycle; s_ready=0 in the abort cycle (no sample is accepted).
  - abort in IDLE: accu_clr pulses and the state stays IDLE.
- Simultaneous events:
  - abort beats start and beats an m_ready handshake.
  - start outside IDLE is ignored.
  - cont changing mid-window affects only the decision made at the OUT handshake.
- Widths: m_data is the full DATA_W+1 signed accumulator output, never truncated. The controller does no arithmetic besides win_cnt.
- Async reset mid-window: everything returns to reset values immediately, the partial sum is discarded, and no m_valid is issued. The accumulator is cleared by the next CLEAR.

Test Plan:
- Single window: reset, start, s_data=1..50 back-to-back, m_ready=1 -> m_valid one pulse with m_data=1275; win_cnt=50 in CAPTURE; return to IDLE; busy=0.
- Signed and bubbles: s_data=-3 with s_valid toggling every other cycle -> m_data=-150 (0x…F6A, sign-extended); accu_en_n low only on accepted cycles; 50 accepted samples total.
- Backpressure: hold m_ready=0 for 10 cycles after m_valid rises -> m_valid and m_data stay stable; s_ready=0 throughout; handshake on cycle 11 -> IDLE.
- Continuous mode: cont=1, two windows of s_data=1 then s_data=2 -> m_data=50 then 100; exactly one accu_clr cycle before each window; no carry-over between windows.
- Abort: abort after 20 accepted samples -> IDLE next cycle, accu_clr=1 in the abort cycle, no m_valid. A following start plus 50 ones -> m_data=50.
- Reset mid-operation: assert rst asynchronously (between edges) in ACCUM at win_cnt=30, and again in OUT with m_valid=1 -> all outputs take reset values immediately; start after release produces a correct fresh sum.
